mem_responder: RTL and testbench

Word-granularity backing-memory responder that services the memory-side interface driven by the cache (`o_mem_*` outputs / `i_mem_*` inputs on the cache become inputs/outputs here). It holds a `DEPTH`-word array and accepts one request at a time with a ready/valid handshake and a fixed, parameterised latency. It completes reads with a one-cycle valid pulse and commits writes at acceptance. It is the memory end of the cache's miss-fill and write-through traffic, both in the integrated system and on cache benches.

---
 rtl/mem_responder_pkg.sv | 9 +
 rtl/mem_responder_if.sv | 15 +
 rtl/mem_responder_lfsr8.sv | 12 +
 rtl/mem_responder.sv | 70 +++++++
 tb/tb_mem_responder.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared FSM encoding, LFSR constants and sizing helper for mem_responder.
package mem_responder_pkg;
  typedef enum logic {IDLE, WAIT} state_t;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: memory-side request/response bus between a cache (master) and the responder (slave).
interface mem_responder_if;
  logic        o_mem_ready;
  logic [31:0] i_mem_addr;
  logic        i_mem_ren;
  logic        i_mem_wen;
  logic [31:0] i_mem_wdata;
  logic [31:0] o_mem_rdata;
  logic        o_mem_valid;
  logic        o_err;
  modport master (input o_mem_ready, o_mem_rdata, o_mem_valid, o_err,
                  output i_mem_addr, i_mem_ren, i_mem_wen, i_mem_wdata);
  modport slave (output o_mem_ready, o_mem_rdata, o_mem_valid, o_err,
                 input i_mem_addr, i_mem_ren, i_mem_wen, i_mem_wdata);
endinterface

// File: rtl/mem_responder_lfsr8.sv
// lfsr8: free-running maximal-length 8-bit LFSR (x^8+x^6+x^5+x^4+1); exists only with MEM_RESPONDER_BACKPRESSURE_EN.
`ifdef MEM_RESPONDER_BACKPRESSURE_EN
module lfsr8 import mem_responder_pkg::*; (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [7:0] o_q
);
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) o_q <= LFSR_SEED;
    else o_q <= {o_q[6:0], ^(o_q & LFSR_TAPS)};
endmodule
`endif

// File: rtl/mem_responder.sv
// mem_responder: word-addressed backing memory with fixed-latency ready/valid responses.
module mem_responder import mem_responder_pkg::*; #(
  parameter int DEPTH     = 4096,
  parameter int LATENCY   = 4,
  parameter     INIT_FILE = ""
) (
  input logic            i_clk,
  input logic            i_rst,
  mem_responder_if.slave bus
);
  localparam int IW = idx_width(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  logic [31:0]   mem [DEPTH];
  state_t        state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx, lat_idx;
  logic          lat_rd, gate, ready, accept, both;
  logic          valid, err;
  logic [31:0]   rdata;
  logic          unused_addr;
`ifdef MEM_RESPONDER_BACKPRESSURE_EN
  logic [7:0] lfsr;
  logic       unused_lfsr;
  lfsr8 u_lfsr (.i_clk(i_clk), .i_rst(i_rst), .o_q(lfsr));
  assign gate = |lfsr[1:0];
  assign unused_lfsr = ^lfsr[7:2];
`else
  assign gate = 1'b1;
`endif
  assign idx         = bus.i_mem_addr[IW+1:2];
  assign unused_addr = ^{bus.i_mem_addr[31:IW+2], bus.i_mem_addr[1:0]};
  assign ready       = (state == IDLE) && gate;
  assign accept      = ready && !i_rst && (bus.i_mem_ren ^ bus.i_mem_wen);
  assign both        = ready && !i_rst && bus.i_mem_ren && bus.i_mem_wen;
  assign bus.o_mem_ready = ready;
  assign bus.o_mem_valid = valid;
  assign bus.o_mem_rdata = rdata;
  assign bus.o_err       = err;
  always_ff @(posedge i_clk)
    if (accept && bus.i_mem_wen) mem[idx] <= bus.i_mem_wdata;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      lat_idx <= '0;
      lat_rd  <= 1'b0;
      valid   <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (both) err <= 1'b1;
      if (state == IDLE) begin
        if (accept) begin
          state   <= WAIT;
          cnt     <= CW'(LATENCY - 1);
          lat_idx <= idx;
          lat_rd  <= bus.i_mem_ren;
        end
      end else if (cnt == '0) begin
        state <= IDLE;
        if (lat_rd) begin
          valid <= 1'b1;
          rdata <= mem[lat_idx];
        end
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder; read expectations are queued at issue and popped on o_mem_valid.
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mem_responder_if bus();
  mem_responder #(.DEPTH(4096), .LATENCY(4), .INIT_FILE("")) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus)
  );
  typedef struct {
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;
  exp_t sbq[$];
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int low_idle = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (bus.o_mem_valid === 1'b1) begin
      if (sbq.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        check({e.name, "_data"}, bus.o_mem_rdata, e.data);
        check({e.name, "_cycle"}, cyc, e.cyc);
      end
    end
  end
  task automatic wait_ready();
    int n = 0;
    while (bus.o_mem_ready !== 1'b1 && n < 50) begin
      low_idle++;
      n++;
      @(negedge clk);
    end
    if (n == 50) check("ready_timeout", 32'd0, 32'd1);
  endtask
  task automatic idle_bus();
    bus.i_mem_ren   = 1'b0;
    bus.i_mem_wen   = 1'b0;
    bus.i_mem_addr  = 32'hFFFF_FFFC;
    bus.i_mem_wdata = 32'h5A5A_5A5A;
  endtask
  task automatic req(input logic [31:0] a, input logic r, input logic [31:0] d, input logic [31:0] e, input string name);
    wait_ready();
    bus.i_mem_addr  = a;
    bus.i_mem_ren   = r;
    bus.i_mem_wen   = !r;
    bus.i_mem_wdata = d;
    if (r) sbq.push_back('{e, cyc + 5, name});
    @(posedge clk);
    #1 idle_bus();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check({name, "_busy"}, {31'd0, bus.o_mem_ready}, 32'd0);
    end
    @(negedge clk);
`ifndef MEM_RESPONDER_BACKPRESSURE_EN
    check({name, "_ready_back"}, {31'd0, bus.o_mem_ready}, 32'd1);
`endif
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    idle_bus();
    #1 rst = 1'b1;
    #1;
    check("rst_ready", {31'd0, bus.o_mem_ready}, 32'd1);
    check("rst_valid", {31'd0, bus.o_mem_valid}, 32'd0);
    check("rst_rdata", bus.o_mem_rdata, 32'd0);
    check("rst_err", {31'd0, bus.o_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req(32'h100, 1'b0, 32'hDEAD_BEEF, 32'h0, "wr100");
    req(32'h100, 1'b1, 32'h0, 32'hDEAD_BEEF, "rd100");
    for (int i = 0; i < 4; i++) req(32'h200 + 32'(4 * i), 1'b0, 32'hA000_0000 + 32'(i * 17), 32'h0, "fill_wr");
    for (int i = 0; i < 4; i++) req(32'h200 + 32'(4 * i), 1'b1, 32'h0, 32'hA000_0000 + 32'(i * 17), $sformatf("fill_rd%0d", i));
    req(32'h0000_4000, 1'b0, 32'h11, 32'h0, "alias_wr");
    req(32'h0000_0000, 1'b1, 32'h0, 32'h11, "alias_rd");
    req(32'h40, 1'b0, 32'hCAFE_0040, 32'h0, "wr40");
    wait_ready();
    bus.i_mem_addr  = 32'h40;
    bus.i_mem_ren   = 1'b1;
    bus.i_mem_wen   = 1'b1;
    bus.i_mem_wdata = 32'h0BAD_0BAD;
    @(posedge clk);
    #1 idle_bus();
    @(negedge clk);
`ifndef MEM_RESPONDER_BACKPRESSURE_EN
    check("both_ready", {31'd0, bus.o_mem_ready}, 32'd1);
`endif
    check("both_err", {31'd0, bus.o_err}, 32'd1);
    req(32'h40, 1'b1, 32'h0, 32'hCAFE_0040, "rd40_after_err");
    check("err_sticky", {31'd0, bus.o_err}, 32'd1);
    req(32'h300, 1'b0, 32'h1234_5678, 32'h0, "wr300");
    wait_ready();
    bus.i_mem_addr = 32'h300;
    bus.i_mem_ren  = 1'b1;
    @(posedge clk);
    #1 idle_bus();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midwait_rst_ready", {31'd0, bus.o_mem_ready}, 32'd1);
    check("midwait_rst_err", {31'd0, bus.o_err}, 32'd0);
    check("midwait_rst_valid", {31'd0, bus.o_mem_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("midwait_rdata_reset", bus.o_mem_rdata, 32'd0);
    req(32'h300, 1'b1, 32'h0, 32'h1234_5678, "rd300_after_rst");
`ifdef MEM_RESPONDER_BACKPRESSURE_EN
    begin
      logic [31:0] model [16];
      low_idle = 0;
      for (int i = 0; i < 16; i++) begin
        model[i] = $urandom;
        req(32'h800 + 32'(4 * i), 1'b0, model[i], 32'h0, "rnd_init");
      end
      for (int n = 0; n < 1000; n++) begin
        int i;
        i = $urandom_range(0, 15);
        if ($urandom_range(0, 1) == 1) begin
          model[i] = $urandom;
          req(32'h800 + 32'(4 * i), 1'b0, model[i], 32'h0, "rnd_wr");
        end else begin
          req(32'h800 + 32'(4 * i), 1'b1, 32'h0, model[i], "rnd_rd");
        end
      end
      check("ready_low_in_idle", {31'd0, low_idle > 0}, 32'd1);
    end
`endif
    repeat (10) @(negedge clk);
    check("scoreboard_drained", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
